mul_div_unit: RTL and testbench

Iterative multiply/divide unit for the execute stage, operating alongside the ALU on the same `opA`/`opB` operands and funct encoding. Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO into architectural HI/LO registers. Exposes `busy` so the hazard unit can stall MFHI/MFLO and any new mul/div. HI/LO drive the writeback mux for MFHI/MFLO.

---
 rtl/mul_div_unit_pkg.sv | 26 ++
 rtl/mdu_iter_core.sv | 58 +++++
 rtl/mul_div_unit.sv | 142 ++++++++++++++
 tb/tb_mul_div_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared ISA funct codes for the HI/LO multiply/divide unit plus small sign helpers.
// Imported by the mul/div datapath and by anything decoding mul/div functs.
package mul_div_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [5:0] FUN_MTHI  = 6'h11;
  localparam logic [5:0] FUN_MTLO  = 6'h13;
  localparam logic [5:0] FUN_MULT  = 6'h18;
  localparam logic [5:0] FUN_MULTU = 6'h19;
  localparam logic [5:0] FUN_DIV   = 6'h1A;
  localparam logic [5:0] FUN_DIVU  = 6'h1B;

  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == FUN_MULT) || (f == FUN_MULTU) || (f == FUN_DIV) || (f == FUN_DIVU);
  endfunction

  function automatic logic [XLEN-1:0] cond_neg32(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg64(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One-bit-per-cycle unsigned datapath: radix-2 shift-add multiply or restoring divide.
// Low half of the accumulator starts as the multiplier/dividend; the operand register holds the other input.
module mdu_iter_core
  import mul_div_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic                 is_div,
  input  logic [XLEN-1:0]      a_in,
  input  logic [XLEN-1:0]      b_in,
  output logic [2*XLEN-1:0]    result
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;

  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     rem_sh;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_sub;

  always_comb begin
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    add_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    // Partial remainder shifted left by one; it can briefly need 33 bits.
    rem_sh  = acc_q[63:31];
    rem_ge  = (rem_sh >= {1'b0, opnd_q});
    rem_sub = rem_sh[31:0] - opnd_q;

    if (load) begin
      acc_d  = {32'd0, a_in};
      opnd_d = b_in;
    end else if (step) begin
      if (is_div) begin
        if (rem_ge) acc_d = {rem_sub, acc_q[30:0], 1'b1};
        else        acc_d = {acc_q[62:0], 1'b0};
      end else begin
        acc_d = {add_sum, acc_q[31:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
    end
  end

  assign result = acc_q;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning the architectural HI/LO registers.
// Magnitudes go through mdu_iter_core for 32 steps; signs are restored in a final FIX cycle.
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [5:0]      funct,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              done_q, done_d;

  logic              core_load;
  logic              core_step;
  logic              signed_op;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [2*XLEN-1:0] core_res;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    core_load = 1'b0;
    core_step = 1'b0;

    signed_op = (funct == FUN_MULT) || (funct == FUN_DIV);
    a_neg     = signed_op & opA[31];
    b_neg     = signed_op & opB[31];
    mag_a     = cond_neg32(opA, a_neg);
    mag_b     = cond_neg32(opB, b_neg);

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          if (is_muldiv(funct)) begin
            core_load = 1'b1;
            is_div_d  = (funct == FUN_DIV) || (funct == FUN_DIVU);
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            cnt_d     = 6'd0;
            state_d   = CALC;
          end else if (funct == FUN_MTHI) begin
            hi_d = opA;
          end else if (funct == FUN_MTLO) begin
            lo_d = opA;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          core_step = 1'b1;
          cnt_d     = cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          // Quotient takes the combined sign; remainder follows the dividend.
          if (is_div_q) begin
            lo_d = cond_neg32(core_res[31:0], neg_res_q);
            hi_d = cond_neg32(core_res[63:32], neg_rem_q);
          end else begin
            {hi_d, lo_d} = cond_neg64(core_res, neg_res_q);
          end
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  mdu_iter_core u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (core_load),
    .step   (core_step),
    .is_div (is_div_q),
    .a_in   (mag_a),
    .b_in   (mag_b),
    .result (core_res)
  );

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed corner cases then random mul/div/mt traffic.
// Expected HI:LO comes from plain integer arithmetic; a monitor pops and compares on each done.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks  = 0;
  int n_fail    = 0;
  int exp_done  = 0;
  int done_seen = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mul_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .funct (funct),
    .opA   (opA),
    .opB   (opB),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result {HI, LO} from ordinary integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = 64'd0;
    if (f == FUN_MULT) begin
      res = 64'(sa * sb);
    end else if (f == FUN_MULTU) begin
      res = {32'd0, a} * {32'd0, b};
    end else if (f == FUN_DIVU) begin
      if (b == 32'd0) res = {a, 32'hFFFFFFFF};
      else            res = {a % b, a / b};
    end else if (f == FUN_DIV) begin
      if (b == 32'd0) begin
        res = {a, (a[31] ? 32'h00000001 : 32'hFFFFFFFF)};
      end else begin
        q   = sa / sb;
        r   = sa % sb;
        res = {r[31:0], q[31:0]};
      end
    end
    return res;
  endfunction

  // Called right after a negedge; returns at the done-cycle negedge (or after an abort).
  // abort_kind: 0 none, 1 flush, 2 reset.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int abort_kind, input int abort_cyc, input int inject_cyc);
    logic [63:0] r;
    int cyc;
    bit aborted;
    r = ref_result(f, a, b);
    aborted = 1'b0;
    if (abort_kind == 0) begin
      exp_q.push_back(r);
      exp_done++;
    end
    start = 1'b1; funct = f; opA = a; opB = b;
    @(posedge clk);
    #1;
    start = 1'b0; opA = $urandom; opB = $urandom;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
      if (cyc > 100) begin
        n_checks++; n_fail++;
        $display("FAIL busy_timeout: got busy after %0d cycles required drop at 33", cyc);
        break;
      end
      start = 1'b0;
      if (inject_cyc == cyc) begin
        start = 1'b1; funct = FUN_DIVU; opA = 32'd9; opB = 32'd3;
      end
      if (abort_kind != 0 && cyc == abort_cyc) begin
        if (abort_kind == 1) flush = 1'b1;
        else                 reset = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; reset = 1'b0;
        @(negedge clk);
        if (abort_kind == 2) begin m_hi = 32'd0; m_lo = 32'd0; end
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_hi", hi, m_hi);
        check("abort_lo", lo, m_lo);
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      check("latency", 32'(cyc), 32'd33);
      check("done_cycle", {31'd0, done}, 32'd1);
      m_hi = r[63:32];
      m_lo = r[31:0];
    end
    $display("op f=%h a=%h b=%h abort=%0d -> hi=%h lo=%h", f, a, b, abort_kind, hi, lo);
  endtask

  task automatic run_mt(input logic [5:0] f, input logic [31:0] a, input bit with_flush);
    start = 1'b1; funct = f; opA = a; flush = with_flush;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    if (!with_flush) begin
      if (f == FUN_MTHI) m_hi = a;
      else               m_lo = a;
    end
    check("mt_busy", {31'd0, busy}, 32'd0);
    check("mt_hi", hi, m_hi);
    check("mt_lo", lo, m_lo);
    $display("mt f=%h a=%h flush=%0d -> hi=%h lo=%h", f, a, with_flush, hi, lo);
  endtask

  // Scoreboard monitor.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: got done=1 with hi=%h lo=%h required no done", hi, lo);
        end else begin
          e = exp_q.pop_front();
          check("sb_hi", hi, e[63:32]);
          check("sb_lo", lo, e[31:0]);
        end
      end
    end
  end

  initial begin
    logic [5:0] ops [4];
    logic [5:0] f;
    logic [31:0] a, b;
    ops[0] = FUN_MULT; ops[1] = FUN_MULTU; ops[2] = FUN_DIV; ops[3] = FUN_DIVU;
    reset = 1'b1; start = 1'b0; flush = 1'b0; funct = 6'd0; opA = 32'd0; opB = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b0;

    run_op(FUN_MULT, 32'hFFFFFFFF, 32'd5, 0, 0, 0);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFB);
    run_op(FUN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);
    run_op(FUN_DIV, 32'hFFFFFFF9, 32'd2, 0, 0, 0);
    check("div_hi", hi, 32'hFFFFFFFF);
    check("div_lo", lo, 32'hFFFFFFFD);
    run_op(FUN_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0);
    check("div_ovf_hi", hi, 32'h0);
    check("div_ovf_lo", lo, 32'h80000000);
    run_op(FUN_DIVU, 32'd100, 32'd0, 0, 0, 0);
    check("divu0_hi", hi, 32'd100);
    check("divu0_lo", lo, 32'hFFFFFFFF);
    run_op(FUN_DIV, 32'hFFFFFFF9, 32'd0, 0, 0, 0);
    check("div0neg_hi", hi, 32'hFFFFFFF9);
    check("div0neg_lo", lo, 32'h00000001);

    run_mt(FUN_MTHI, 32'h1234, 1'b0);
    run_op(FUN_DIVU, 32'd50, 32'd7, 1, 10, 0);
    check("flush_hi", hi, 32'h1234);
    run_mt(FUN_MTLO, 32'hDEADBEEF, 1'b1);

    run_op(FUN_MULTU, 32'd3, 32'd4, 0, 0, 5);
    check("inject_hi", hi, 32'd0);
    check("inject_lo", lo, 32'd12);

    run_op(FUN_MULT, 32'h01234567, 32'd89, 2, 20, 0);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        run_mt(($urandom_range(0, 1) == 0) ? FUN_MTHI : FUN_MTLO, $urandom, 1'b0);
      end else begin
        f = ops[$urandom_range(0, 3)];
        a = $urandom;
        case ($urandom_range(0, 4))
          0:       b = 32'd0;
          1:       b = 32'($urandom_range(1, 15));
          2:       b = 32'hFFFFFFFF;
          default: b = $urandom;
        endcase
        run_op(f, a, b, 0, 0, 0);
      end
    end

    repeat (4) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(done_seen), 32'(exp_done));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
